// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receive path: pin conditioning, 11-bit deframing with
// parity/stop/timeout checking, and scan-code set 2 decoding of digits and WASD.
module ps2_key_decoder #(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       frame_err,
  output logic [4:0] numbers,
  output logic       num_valid,
  output logic [3:0] dir_held,
  output logic [2:0] directions
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] CODE_BRK = 8'hF0;
  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [4:0] NO_DIGIT = 5'b11111;

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  // Index 0 carries ps2_clk, index 1 carries ps2_data.
  logic [1:0]    sync1, sync2, filt;
  logic [FW-1:0] fcnt [2];
  logic          clk_flip;
  logic          fall;
  logic          rx_bit;

  state_t        state, state_nxt;
  logic [3:0]    bitcnt;
  logic [TW-1:0] tcnt;
  logic [9:0]    shreg;
  logic          timeout;
  logic          good_c, bad_c;
  logic          brk, ext;
  logic [7:0]    code;
  logic [4:0]    digit;
  logic [3:0]    dir_bit;

  assign clk_flip = (sync2[0] != filt[0]) && (fcnt[0] == FW'(FILTER_LEN - 1));
  assign rx_bit   = filt[1];
  assign timeout  = (state == RECV) && !fall && (tcnt == TW'(TIMEOUT_CYCLES));
  assign code     = shreg[7:0];

  // Scan-code set 2 digit lookup; NO_DIGIT for anything else.
  function automatic logic [4:0] digit_of(input logic [7:0] c);
    case (c)
      8'h45:   digit_of = 5'd0;
      8'h16:   digit_of = 5'd1;
      8'h1E:   digit_of = 5'd2;
      8'h26:   digit_of = 5'd3;
      8'h25:   digit_of = 5'd4;
      8'h2E:   digit_of = 5'd5;
      8'h36:   digit_of = 5'd6;
      8'h3D:   digit_of = 5'd7;
      8'h3E:   digit_of = 5'd8;
      8'h46:   digit_of = 5'd9;
      default: digit_of = NO_DIGIT;
    endcase
  endfunction

  // Held-mask bit for W/A/S/D; zero for other codes.
  function automatic logic [3:0] dir_of(input logic [7:0] c);
    case (c)
      8'h1D:   dir_of = 4'b1000;
      8'h1C:   dir_of = 4'b0100;
      8'h1B:   dir_of = 4'b0010;
      8'h23:   dir_of = 4'b0001;
      default: dir_of = 4'b0000;
    endcase
  endfunction

  assign digit   = digit_of(code);
  assign dir_bit = dir_of(code);

  // Two-flop synchronisers followed by a run-length glitch filter on each pin.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 2'b11;
      sync2   <= 2'b11;
      filt    <= 2'b11;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
    end else begin
      sync1 <= {ps2_data, ps2_clk};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
          filt[i] <= ~filt[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FW'(1);
        end
      end
    end
  end

  // One-cycle strobe when the filtered clock goes from high to low.
  always_ff @(posedge clk) begin
    if (reset) fall <= 1'b0;
    else       fall <= clk_flip && filt[0];
  end

  // Receiver state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Receiver next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fall && !rx_bit) state_nxt = RECV;
      RECV: begin
        if (fall && (bitcnt == 4'd10)) state_nxt = CHECK;
        else if (timeout)              state_nxt = IDLE;
      end
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Receiver outputs: frame verdict in CHECK, abort strobe on timeout.
  always_comb begin
    good_c = 1'b0;
    bad_c  = 1'b0;
    case (state)
      CHECK: begin
        if ((^shreg[8:0]) && shreg[9]) good_c = 1'b1;
        else                           bad_c  = 1'b1;
      end
      RECV:    bad_c = timeout;
      default: ;
    endcase
  end

  // Bit counter, inactivity counter and LSB-first shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      bitcnt <= '0;
      tcnt   <= '0;
      shreg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (fall && !rx_bit) bitcnt <= 4'd1;
        end
        RECV: begin
          if (fall) begin
            shreg  <= {rx_bit, shreg[9:1]};
            bitcnt <= bitcnt + 4'd1;
            tcnt   <= '0;
          end else if (timeout) begin
            tcnt <= '0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: begin
          bitcnt <= '0;
          tcnt   <= '0;
        end
      endcase
    end
  end

  // Byte decoder: prefix flags, digit capture and held-key mask.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_code  <= 8'h00;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      numbers    <= NO_DIGIT;
      num_valid  <= 1'b0;
      dir_held   <= 4'b0000;
      brk        <= 1'b0;
      ext        <= 1'b0;
    end else begin
      code_valid <= good_c;
      frame_err  <= bad_c;
      num_valid  <= 1'b0;
      if (bad_c) begin
        brk <= 1'b0;
        ext <= 1'b0;
      end else if (good_c) begin
        scan_code <= code;
        if (code == CODE_BRK) begin
          brk <= 1'b1;
        end else if (code == CODE_EXT) begin
          ext <= 1'b1;
        end else if (ext) begin
          brk <= 1'b0;
          ext <= 1'b0;
        end else if (brk) begin
          dir_held <= dir_held & ~dir_bit;
          brk      <= 1'b0;
        end else begin
          if (digit != NO_DIGIT) begin
            numbers   <= digit;
            num_valid <= 1'b1;
          end
          dir_held <= dir_held | dir_bit;
        end
      end
    end
  end

  // Direction code from the held mask, priority W > S > A > D.
  always_ff @(posedge clk) begin
    if (reset)            directions <= 3'b111;
    else if (dir_held[3]) directions <= 3'b001;
    else if (dir_held[1]) directions <= 3'b011;
    else if (dir_held[2]) directions <= 3'b100;
    else if (dir_held[0]) directions <= 3'b010;
    else                  directions <= 3'b111;
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed vector table, randomized
// frames against a byte-level reference model, and timeout/glitch/reset cases.
module tb_ps2_key_decoder;

  localparam int unsigned TO = 200;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scan_code;
  logic       code_valid;
  logic       frame_err;
  logic [4:0] numbers;
  logic       num_valid;
  logic [3:0] dir_held;
  logic [2:0] directions;

  ps2_key_decoder #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .scan_code  (scan_code),
    .code_valid (code_valid),
    .frame_err  (frame_err),
    .numbers    (numbers),
    .num_valid  (num_valid),
    .dir_held   (dir_held),
    .directions (directions)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Pulse counters and pulse-width watch, sampled on the falling edge.
  int cv_cnt = 0, err_cnt = 0, nv_cnt = 0, wide_pulses = 0;
  logic p_cv = 1'b0, p_err = 1'b0, p_nv = 1'b0;
  always @(negedge clk) begin
    if (code_valid) cv_cnt++;
    if (frame_err)  err_cnt++;
    if (num_valid)  nv_cnt++;
    if ((code_valid && p_cv) || (frame_err && p_err) || (num_valid && p_nv)) wide_pulses++;
    p_cv  = code_valid;
    p_err = frame_err;
    p_nv  = num_valid;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Behavioural model: byte stream in, key state out.
  logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                   8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] dir_codes [4]    = '{8'h23, 8'h1B, 8'h1C, 8'h1D}; // index = held bit
  int         prio_bit [4]     = '{3, 1, 2, 0};                 // W, S, A, D
  logic [2:0] prio_code [4]    = '{3'b001, 3'b011, 3'b100, 3'b010};

  logic [7:0] m_scan = 8'h00;
  int         m_num  = 31;
  logic [3:0] m_held = 4'b0000;
  bit         m_brk  = 1'b0, m_ext = 1'b0;
  int         exp_cv = 0, exp_err = 0, exp_nv = 0;

  function automatic logic [2:0] model_dirs(input logic [3:0] held);
    for (int k = 0; k < 4; k++)
      if (held[prio_bit[k]]) return prio_code[k];
    return 3'b111;
  endfunction

  task automatic model_frame(input logic [7:0] c, input bit bad);
    if (bad) begin
      exp_err++;
      m_brk = 1'b0;
      m_ext = 1'b0;
      return;
    end
    exp_cv++;
    m_scan = c;
    if (c == 8'hF0) m_brk = 1'b1;
    else if (c == 8'hE0) m_ext = 1'b1;
    else if (m_ext) begin
      m_brk = 1'b0;
      m_ext = 1'b0;
    end else if (m_brk) begin
      for (int k = 0; k < 4; k++) if (dir_codes[k] == c) m_held[k] = 1'b0;
      m_brk = 1'b0;
    end else begin
      for (int d = 0; d < 10; d++)
        if (digit_codes[d] == c) begin
          m_num = d;
          exp_nv++;
        end
      for (int k = 0; k < 4; k++) if (dir_codes[k] == c) m_held[k] = 1'b1;
    end
  endtask

  // Pin-level frame driver: data set while clock high, then clock pulsed low.
  function automatic logic [10:0] mk_frame(input logic [7:0] c, input bit bad);
    logic par;
    par = ~(^c) ^ bad;
    return {1'b1, par, c, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      wait_cyc(10);
      ps2_clk = 1'b0;
      wait_cyc(10);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] c, input bit bad);
    send_bits(mk_frame(c, bad), 11);
    wait_cyc(20);
  endtask

  task automatic check_model(input string tag);
    chk({tag, " scan"},  32'(scan_code),  32'(m_scan));
    chk({tag, " num"},   32'(numbers),    m_num);
    chk({tag, " held"},  32'(dir_held),   32'(m_held));
    chk({tag, " dir"},   32'(directions), 32'(model_dirs(m_held)));
    chk({tag, " ncv"},   cv_cnt,  exp_cv);
    chk({tag, " nerr"},  err_cnt, exp_err);
    chk({tag, " nnv"},   nv_cnt,  exp_nv);
  endtask

  typedef struct {
    logic [7:0] code;
    bit         bad;
    logic [7:0] scan;
    logic [4:0] num;
    logic [3:0] held;
    logic [2:0] dir;
    int         dcv;
    int         derr;
    int         dnv;
  } vec_t;

  vec_t tbl [16];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0, e0, n0;
    logic [7:0] rc;
    bit rbad;

    tbl[0]  = '{8'h16, 1'b0, 8'h16, 5'd1,  4'b0000, 3'b111, 1, 0, 1};
    tbl[1]  = '{8'hF0, 1'b0, 8'hF0, 5'd1,  4'b0000, 3'b111, 1, 0, 0};
    tbl[2]  = '{8'h16, 1'b0, 8'h16, 5'd1,  4'b0000, 3'b111, 1, 0, 0};
    tbl[3]  = '{8'h1C, 1'b0, 8'h1C, 5'd1,  4'b0100, 3'b100, 1, 0, 0};
    tbl[4]  = '{8'h1D, 1'b0, 8'h1D, 5'd1,  4'b1100, 3'b001, 1, 0, 0};
    tbl[5]  = '{8'hF0, 1'b0, 8'hF0, 5'd1,  4'b1100, 3'b001, 1, 0, 0};
    tbl[6]  = '{8'h1D, 1'b0, 8'h1D, 5'd1,  4'b0100, 3'b100, 1, 0, 0};
    tbl[7]  = '{8'hF0, 1'b0, 8'hF0, 5'd1,  4'b0100, 3'b100, 1, 0, 0};
    tbl[8]  = '{8'h1C, 1'b0, 8'h1C, 5'd1,  4'b0000, 3'b111, 1, 0, 0};
    tbl[9]  = '{8'hE0, 1'b0, 8'hE0, 5'd1,  4'b0000, 3'b111, 1, 0, 0};
    tbl[10] = '{8'h1D, 1'b0, 8'h1D, 5'd1,  4'b0000, 3'b111, 1, 0, 0};
    tbl[11] = '{8'hE0, 1'b0, 8'hE0, 5'd1,  4'b0000, 3'b111, 1, 0, 0};
    tbl[12] = '{8'hF0, 1'b0, 8'hF0, 5'd1,  4'b0000, 3'b111, 1, 0, 0};
    tbl[13] = '{8'h1D, 1'b0, 8'h1D, 5'd1,  4'b0000, 3'b111, 1, 0, 0};
    tbl[14] = '{8'h45, 1'b1, 8'h1D, 5'd1,  4'b0000, 3'b111, 0, 1, 0};
    tbl[15] = '{8'h45, 1'b0, 8'h45, 5'd0,  4'b0000, 3'b111, 1, 0, 1};

    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(5);
    reset = 1'b0;
    wait_cyc(10);

    chk("reset scan", 32'(scan_code),  32'h00);
    chk("reset num",  32'(numbers),    32'h1F);
    chk("reset held", 32'(dir_held),   32'h0);
    chk("reset dir",  32'(directions), 32'h7);
    chk("reset pulses", cv_cnt + err_cnt + nv_cnt, 0);

    // Directed vectors.
    for (int i = 0; i < 16; i++) begin
      c0 = cv_cnt; e0 = err_cnt; n0 = nv_cnt;
      send_frame(tbl[i].code, tbl[i].bad);
      model_frame(tbl[i].code, tbl[i].bad);
      chk($sformatf("vec%0d scan", i), 32'(scan_code),  32'(tbl[i].scan));
      chk($sformatf("vec%0d num", i),  32'(numbers),    32'(tbl[i].num));
      chk($sformatf("vec%0d held", i), 32'(dir_held),   32'(tbl[i].held));
      chk($sformatf("vec%0d dir", i),  32'(directions), 32'(tbl[i].dir));
      chk($sformatf("vec%0d dcv", i),  cv_cnt - c0,  tbl[i].dcv);
      chk($sformatf("vec%0d derr", i), err_cnt - e0, tbl[i].derr);
      chk($sformatf("vec%0d dnv", i),  nv_cnt - n0,  tbl[i].dnv);
    end

    // Randomized frames against the model.
    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: rc = digit_codes[$urandom_range(0, 9)];
        4, 5:       rc = dir_codes[$urandom_range(0, 3)];
        6:          rc = 8'hF0;
        7:          rc = 8'hE0;
        default:    rc = 8'($urandom_range(0, 255));
      endcase
      rbad = ($urandom_range(0, 9) == 0);
      send_frame(rc, rbad);
      model_frame(rc, rbad);
      check_model($sformatf("rnd%0d", i));
    end

    // Timeout: clock stops after five bits.
    c0 = cv_cnt; e0 = err_cnt;
    send_bits(mk_frame(8'h3E, 1'b0), 5);
    wait_cyc(TO + 10);
    chk("timeout derr", err_cnt - e0, 1);
    chk("timeout dcv",  cv_cnt - c0,  0);
    exp_err++;
    m_brk = 1'b0;
    m_ext = 1'b0;
    send_frame(8'h3E, 1'b0);
    model_frame(8'h3E, 1'b0);
    chk("after timeout num", 32'(numbers), 8);
    check_model("after timeout");

    // Short low glitch on ps2_clk with data low must not start a frame.
    c0 = cv_cnt; e0 = err_cnt;
    ps2_data = 1'b0;
    wait_cyc(10);
    ps2_clk = 1'b0;
    wait_cyc(2);
    ps2_clk = 1'b1;
    wait_cyc(10);
    ps2_data = 1'b1;
    wait_cyc(20);
    chk("glitch dcv",  cv_cnt - c0,  0);
    chk("glitch derr", err_cnt - e0, 0);
    send_frame(8'h16, 1'b0);
    model_frame(8'h16, 1'b0);
    chk("after glitch scan", 32'(scan_code), 32'h16);
    chk("after glitch num",  32'(numbers),   1);
    check_model("after glitch");

    // Make a key held, then reset in the middle of the next frame.
    send_frame(8'h1B, 1'b0);
    model_frame(8'h1B, 1'b0);
    chk("pre-reset dir", 32'(directions), 32'(3'b011));
    send_bits(mk_frame(8'h1D, 1'b0), 5);
    c0 = cv_cnt; e0 = err_cnt; n0 = nv_cnt;
    reset = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(TO + 20);
    chk("midreset scan", 32'(scan_code),  32'h00);
    chk("midreset num",  32'(numbers),    32'h1F);
    chk("midreset held", 32'(dir_held),   32'h0);
    chk("midreset dir",  32'(directions), 32'h7);
    chk("midreset pulses", (cv_cnt - c0) + (err_cnt - e0) + (nv_cnt - n0), 0);
    m_scan = 8'h00; m_num = 31; m_held = 4'b0000; m_brk = 1'b0; m_ext = 1'b0;
    exp_cv = cv_cnt; exp_err = err_cnt; exp_nv = nv_cnt;
    send_frame(8'h25, 1'b0);
    model_frame(8'h25, 1'b0);
    chk("after reset num", 32'(numbers), 4);
    check_model("after reset");

    chk("pulse width", wide_pulses, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
